// File: rtl/fcpu_pkg.sv
// Shared fcpu types and sizes: result/register widths, CDB layout, commit
// classes and the reorder-buffer entry record.
package fcpu_pkg;

    localparam int N_ROB_W    = 4;
    localparam int N_ROB      = 2 ** N_ROB_W;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RSV_ID_W   = 5;
    localparam int CDB_W      = RSV_ID_W + DATA_W;

    typedef enum logic [2:0] {
        commit_none   = 3'd0,
        commit_int    = 3'd1,
        commit_load   = 3'd2,
        commit_store  = 3'd3,
        commit_branch = 3'd4
    } commit_type_t;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  mispredict;
        commit_type_t          ctype;
        logic [REG_ADDR_W-1:0] dst_reg;
        logic [DATA_W-1:0]     data;
    } rob_entry_t;

endpackage

// File: rtl/fcpu_rob.sv
// Reorder buffer: allocates entries in program order, collects results from
// the CDB, retires from the head in order and flushes on a mispredicted branch.
module fcpu_rob
    import fcpu_pkg::*;
#(
    parameter int N_ROB_W    = fcpu_pkg::N_ROB_W,
    parameter int DATA_W     = fcpu_pkg::DATA_W,
    parameter int REG_ADDR_W = fcpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  commit_type_t          alloc_type,
    input  logic [REG_ADDR_W-1:0] alloc_dst_reg,
    output logic [N_ROB_W-1:0]    alloc_tag,
    input  logic                  cdb_valid,
    input  logic [CDB_W-1:0]      cdb,
    input  logic                  cdb_mispredict,
    output logic                  commit_valid,
    input  logic                  commit_ready,
    output commit_type_t          commit_type,
    output logic [REG_ADDR_W-1:0] commit_dst_reg,
    output logic [DATA_W-1:0]     commit_data,
    output logic [N_ROB_W-1:0]    commit_tag,
    output logic                  flush,
    output logic [N_ROB_W:0]      count
);

    localparam int DEPTH = 2 ** N_ROB_W;

    rob_entry_t             rob_reg [DEPTH];
    rob_entry_t             head_entry;
    logic [N_ROB_W-1:0]     head_reg;
    logic [N_ROB_W-1:0]     tail_reg;
    logic [N_ROB_W:0]       count_reg;
    logic [N_ROB_W:0]       count_next;
    logic [N_ROB_W-1:0]     cdb_idx;
    logic [DATA_W-1:0]      cdb_data;
    logic                   cdb_hit;
    logic                   alloc_fire;
    logic                   commit_fire;
    logic                   cdb_tag_unused;

    // Only the low tag bits address the ROB; the rest identify the station.
    assign cdb_idx        = cdb[DATA_W +: N_ROB_W];
    assign cdb_data       = cdb[DATA_W-1:0];
    assign cdb_tag_unused = ^cdb[CDB_W-1:DATA_W+N_ROB_W];

    assign head_entry  = rob_reg[head_reg];
    assign alloc_ready = (count_reg != (N_ROB_W+1)'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign cdb_hit     = cdb_valid && rob_reg[cdb_idx].valid;

    assign commit_valid   = head_entry.valid && head_entry.done;
    assign commit_fire    = commit_valid && commit_ready;
    assign commit_type    = head_entry.ctype;
    assign commit_dst_reg = head_entry.dst_reg;
    assign commit_data    = head_entry.data;
    assign commit_tag     = head_reg;
    assign flush          = commit_fire && (head_entry.ctype == commit_branch)
                            && head_entry.mispredict;

    assign alloc_tag = tail_reg;
    assign count     = count_reg;

    always_comb begin
        count_next = count_reg;
        if (alloc_fire && !commit_fire) begin
            count_next = count_reg + {{N_ROB_W{1'b0}}, 1'b1};
        end else if (!alloc_fire && commit_fire) begin
            count_next = count_reg - {{N_ROB_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (alloc_fire) begin
                tail_reg <= tail_reg + N_ROB_W'(1);
            end
            if (commit_fire) begin
                head_reg <= head_reg + N_ROB_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // A CDB hit needs an already-valid entry, so it can never collide with the
    // entry being allocated; a commit always wins on the head entry's valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_reg[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_reg[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_hit && (cdb_idx == N_ROB_W'(i))) begin
                    rob_reg[i].done       <= 1'b1;
                    rob_reg[i].data       <= cdb_data;
                    rob_reg[i].mispredict <= cdb_mispredict;
                end
                if (alloc_fire && (tail_reg == N_ROB_W'(i))) begin
                    rob_reg[i].valid      <= 1'b1;
                    rob_reg[i].done       <= 1'b0;
                    rob_reg[i].mispredict <= 1'b0;
                    rob_reg[i].ctype      <= alloc_type;
                    rob_reg[i].dst_reg    <= alloc_dst_reg;
                end
                if (commit_fire && (head_reg == N_ROB_W'(i))) begin
                    rob_reg[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/fcpu_rob.md
FCPU_ROB -- requirements
Module: fcpu_rob

Interface
REQ-001 SHALL have parameter N_ROB_W, default fcpu_pkg::N_ROB_W (4); depth N_ROB = 2**N_ROB_W entries (16).
REQ-002 SHALL have parameter DATA_W, default fcpu_pkg::DATA_W (32); result data width.
REQ-003 SHALL have parameter REG_ADDR_W, default fcpu_pkg::REG_ADDR_W (5); architectural register address width.
REQ-004 SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 alloc_valid  in  1  dispatch requests a ROB entry.
REQ-008 alloc_ready  out  1  an entry is free.
REQ-009 alloc_type  in  commit_type_t (3)  commit class of the dispatched instruction.
REQ-010 alloc_dst_reg  in  REG_ADDR_W  destination register; ignored for commit_branch.
REQ-011 alloc_tag  out  N_ROB_W  index granted; equals the tail pointer.
REQ-012 cdb_valid  in  1  common data bus broadcast valid.
REQ-013 cdb  in  CDB_W (37)  {tag[RSV_ID_W-1:0], data[DATA_W-1:0]}; tag low N_ROB_W bits select the entry.
REQ-014 cdb_mispredict  in  1  with cdb_valid, marks a branch result as mispredicted.
REQ-015 commit_valid  out  1  head entry is valid and done.
REQ-016 commit_ready  in  1  register file / store unit accepts the commit.
REQ-017 commit_type, commit_dst_reg, commit_data, commit_tag  out  3/REG_ADDR_W/DATA_W/N_ROB_W  head entry fields.
REQ-018 flush  out  1  one-cycle pulse: a mispredicted branch committed.
REQ-019 count  out  N_ROB_W+1  number of valid entries (0..16).

Function
REQ-020 Storage SHALL be a circular buffer: head, tail (N_ROB_W bits, wrap 15->0) and count; per entry valid, done, type, dst_reg, data, mispredict.
REQ-021 alloc_ready SHALL be (count != N_ROB); no same-cycle bypass of a commit into a full buffer.
REQ-022 Allocation handshake (alloc_valid && alloc_ready) SHALL write entry[tail] {valid=1, done=0, mispredict=0, type, dst}, then tail+1.
REQ-023 cdb_valid to a valid entry SHALL set done=1, data=cdb data, mispredict=cdb_mispredict on the next edge; to an invalid entry it SHALL be ignored.
REQ-024 commit_valid SHALL be combinational from entry[head].valid && done; earliest commit_valid is one cycle after the CDB write.
REQ-025 Commit handshake (commit_valid && commit_ready) SHALL clear entry[head].valid, then head+1; commit order is strictly allocation order.
REQ-026 Simultaneous alloc and commit SHALL leave count unchanged; alloc alone +1; commit alone -1.
REQ-027 flush SHALL be combinational = commit handshake && commit_type==commit_branch && head mispredict.
REQ-028 On flush, next edge SHALL clear all valid bits, head=tail=0, count=0; allocation and CDB writes in the flush cycle SHALL be discarded.
REQ-029 CDB write to the entry being allocated in the same cycle SHALL be impossible (entry invalid); it SHALL be ignored.

Reset
REQ-030 On rst_n low, asynchronously: all valid=0, head=tail=0, count=0; thus commit_valid=0, flush=0, alloc_ready=1, alloc_tag=0, count=0.
REQ-031 Reset mid-operation SHALL discard all in-flight entries with no commit or flush pulse.

Structure
REQ-032 fcpu_pkg SHALL gain N_ROB localparam and rob_entry_t packed struct; commit_type_t and CDB_W SHALL be reused from fcpu_pkg.
REQ-033 No sub-module; storage and pointers SHALL be inline in fcpu_rob.

Verification
REQ-034 Reset, then 16 allocs with no CDB -> alloc_tag 0..15, count=16, alloc_ready=0, commit_valid=0.
REQ-035 Alloc tags 0,1,2; CDB tag 2 data 0x33, then tag 0 data 0x11 -> commits only after tag 0 done, order 0,1(after its CDB),2 with data 0x11,-,0x33.
REQ-036 Full buffer, commit_ready=1 and alloc_valid=1 same cycle -> commit occurs, alloc rejected, count=15; next cycle alloc accepted, count=16.
REQ-037 Wrap: 20 alloc/commit pairs -> alloc_tag sequence 0..15,0..3, head/tail wrap, no spurious commit.
REQ-038 Alloc branch (tag 0) + integer (tag 1); CDB tag 0 mispredict=1 -> commit of tag 0 asserts flush one cycle; next cycle count=0, tag 1 never commits.
